// File: rtl/micro_ucr_hash_driver.sv
// micro_ucr_hash_driver
//    Drives an external hash engine through a nonce search. Each round sends
//    block_out = {nonce counter, payload} with a one-cycle hash_init strobe,
//    then a one-cycle valid strobe. It waits for an armed hash_ready and
//    compares hash[23:8] against target. The search stops on a hit, on
//    reaching max_nonce, or when the engine fails to answer within TIMEOUT
//    WAIT cycles.
//
// Ports
//    clk        : rising-edge clock
//    reset      : asynchronous active-low reset
//    start      : begin a search (ignored while busy)
//    payload    : 96-bit fixed block bytes
//    target     : 16-bit difficulty threshold
//    max_nonce  : last nonce tried
//    hash_init  : engine start strobe (one cycle per round)
//    valid      : qualifies block_out (one cycle per round, after hash_init)
//    block_out  : {nonce[31:0], payload[95:0]} presented to the engine
//    hash_in    : 24-bit engine result
//    hash_ready : engine result valid
//    nonce      : winning nonce
//    found/done/error/busy : search status
module micro_ucr_hash_driver #(
   parameter int TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [95:0]  payload,
   input  logic [15:0]  target,
   input  logic [31:0]  max_nonce,
   output logic         hash_init,
   output logic         valid,
   output logic [127:0] block_out,
   input  logic [23:0]  hash_in,
   input  logic         hash_ready,
   output logic [31:0]  nonce,
   output logic         found,
   output logic         done,
   output logic         error,
   output logic         busy
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // Value of the WAIT counter during the TIMEOUT-th WAIT cycle.
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      SEND  = 3'd2,
      WAIT  = 3'd3,
      CHECK = 3'd4
   } state_t;

   state_t         r_state,     w_state;
   logic [95:0]    r_payload,   w_payload;
   logic [15:0]    r_target,    w_target;
   logic [31:0]    r_max,       w_max;
   logic [31:0]    r_cnt,       w_cnt;
   logic [TW-1:0]  r_tmo,       w_tmo;
   logic           r_armed,     w_armed;
   logic [15:0]    r_hash,      w_hash;
   logic           r_hash_init, w_hash_init;
   logic           r_valid,     w_valid;
   logic [127:0]   r_block,     w_block;
   logic [31:0]    r_nonce,     w_nonce;
   logic           r_found,     w_found;
   logic           r_done,      w_done;
   logic           r_error,     w_error;
   logic           r_busy,      w_busy;

   // Only hash bits [23:8] take part in the difficulty compare.
   logic w_unused_hash_lsb;
   assign w_unused_hash_lsb = ^hash_in[7:0];

   // Next-state, datapath and registered-output computation.
   always_comb begin
      w_state     = r_state;
      w_payload   = r_payload;
      w_target    = r_target;
      w_max       = r_max;
      w_cnt       = r_cnt;
      w_tmo       = r_tmo;
      w_armed     = r_armed;
      w_hash      = r_hash;
      w_hash_init = 1'b0;
      w_valid     = 1'b0;
      w_block     = r_block;
      w_nonce     = r_nonce;
      w_found     = r_found;
      w_done      = r_done;
      w_error     = r_error;
      w_busy      = r_busy;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_payload   = payload;
               w_target    = target;
               w_max       = max_nonce;
               w_cnt       = 32'd0;
               w_found     = 1'b0;
               w_done      = 1'b0;
               w_error     = 1'b0;
               w_busy      = 1'b1;
               // Outputs are registered, so the INIT-cycle values are loaded here.
               w_block     = {32'd0, payload};
               w_hash_init = 1'b1;
               w_state     = INIT;
            end else begin
               w_state = IDLE;
            end
         end
         INIT: begin
            w_armed = 1'b0;
            w_valid = 1'b1;
            w_state = SEND;
         end
         SEND: begin
            w_tmo   = {TW{1'b0}};
            w_state = WAIT;
         end
         WAIT: begin
            if (hash_ready && r_armed) begin
               w_hash  = hash_in[23:8];
               w_state = CHECK;
            end else begin
               // A low hash_ready proves any earlier high level was stale.
               if (!hash_ready) begin
                  w_armed = 1'b1;
               end else begin
                  w_armed = r_armed;
               end
               if (r_tmo == TMO_LAST) begin
                  w_error = 1'b1;
                  w_done  = 1'b1;
                  w_busy  = 1'b0;
                  w_state = IDLE;
               end else begin
                  w_tmo = r_tmo + TW'(1);
               end
            end
         end
         CHECK: begin
            if (r_hash < r_target) begin
               w_nonce = r_cnt;
               w_found = 1'b1;
               w_done  = 1'b1;
               w_busy  = 1'b0;
               w_state = IDLE;
            end else if (r_cnt == r_max) begin
               // Compare before incrementing so max_nonce of all-ones never wraps.
               w_found = 1'b0;
               w_done  = 1'b1;
               w_busy  = 1'b0;
               w_state = IDLE;
            end else begin
               w_cnt       = r_cnt + 32'd1;
               w_block     = {r_cnt + 32'd1, r_payload};
               w_hash_init = 1'b1;
               w_state     = INIT;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_payload   <= 96'd0;
         r_target    <= 16'd0;
         r_max       <= 32'd0;
         r_cnt       <= 32'd0;
         r_tmo       <= {TW{1'b0}};
         r_armed     <= 1'b0;
         r_hash      <= 16'd0;
         r_hash_init <= 1'b0;
         r_valid     <= 1'b0;
         r_block     <= 128'd0;
         r_nonce     <= 32'd0;
         r_found     <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_payload   <= w_payload;
         r_target    <= w_target;
         r_max       <= w_max;
         r_cnt       <= w_cnt;
         r_tmo       <= w_tmo;
         r_armed     <= w_armed;
         r_hash      <= w_hash;
         r_hash_init <= w_hash_init;
         r_valid     <= w_valid;
         r_block     <= w_block;
         r_nonce     <= w_nonce;
         r_found     <= w_found;
         r_done      <= w_done;
         r_error     <= w_error;
         r_busy      <= w_busy;
      end
   end

   assign hash_init = r_hash_init;
   assign valid     = r_valid;
   assign block_out = r_block;
   assign nonce     = r_nonce;
   assign found     = r_found;
   assign done      = r_done;
   assign error     = r_error;
   assign busy      = r_busy;

endmodule

// File: tb/tb_micro_ucr_hash_driver.sv
// Testbench for micro_ucr_hash_driver: directed searches against a small
// hash-engine model, with expected blocks and results queued by the stimulus
// and checked by an independent monitor.
module tb_micro_ucr_hash_driver;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [95:0]  payload;
   logic [15:0]  target;
   logic [31:0]  max_nonce;
   logic         hash_init;
   logic         valid;
   logic [127:0] block_out;
   logic [23:0]  hash_in;
   logic         hash_ready;
   logic [31:0]  nonce;
   logic         found, done, error, busy;

   micro_ucr_hash_driver dut (
      .clk(clk), .reset(reset), .start(start), .payload(payload),
      .target(target), .max_nonce(max_nonce), .hash_init(hash_init),
      .valid(valid), .block_out(block_out), .hash_in(hash_in),
      .hash_ready(hash_ready), .nonce(nonce), .found(found), .done(done),
      .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        found;
      logic [31:0] nonce;
      logic        error;
      int          lat;
   } res_t;

   res_t         exp_res[$];
   logic [127:0] exp_blk[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           model_mode = 0;   // 0 silent, 1 fixed hash, 2 hit at nonce 2, 3 stale ready
   logic [23:0]  model_hash = 24'h0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Hash engine model: answers each valid after a short delay.
   initial begin
      logic [31:0] n;
      logic [23:0] h;
      hash_ready = 1'b0;
      hash_in    = 24'h0;
      forever begin
         @(negedge clk);
         if (reset && valid && model_mode != 0) begin
            n = block_out[127:96];
            case (model_mode)
               1:       h = model_hash;
               2:       h = (n == 32'd2) ? 24'h000000 : 24'hFFFFFF;
               3:       h = 24'h000100;
               default: h = 24'hFFFFFF;
            endcase
            if (model_mode == 3) begin
               @(negedge clk);            // stale high still present in first WAIT cycle
               @(negedge clk);
               hash_ready = 1'b0;         // single-cycle drop
               @(negedge clk);
               hash_ready = 1'b1;
               hash_in    = h;
               @(negedge clk);
               hash_ready = 1'b0;
            end else begin
               @(negedge clk);
               @(negedge clk);
               hash_ready = 1'b1;
               hash_in    = h;
               @(negedge clk);
               hash_ready = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial begin
      logic         prev_init;
      logic         prev_done;
      logic [127:0] last_blk;
      logic [127:0] b;
      res_t         r;
      int           valid_cyc;
      prev_init = 1'b0;
      prev_done = 1'b0;
      last_blk  = 128'd0;
      valid_cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            if (hash_init) begin
               if (exp_blk.size() == 0) begin
                  fail_evt("unexpected_hash_init");
               end else begin
                  b = exp_blk.pop_front();
                  chk("block_at_init", block_out, b);
               end
               chk("init_one_cycle", {127'd0, prev_init}, 128'd0);
               chk("init_valid_excl", {127'd0, valid}, 128'd0);
               last_blk = block_out;
            end
            if (valid) begin
               chk("block_stable_at_valid", block_out, last_blk);
               chk("valid_follows_init", {127'd0, prev_init}, 128'd1);
               valid_cyc = cyc;
            end
            if (done && !prev_done) begin
               if (exp_res.size() == 0) begin
                  fail_evt("unexpected_done");
               end else begin
                  r = exp_res.pop_front();
                  chk("found", {127'd0, found}, {127'd0, r.found});
                  chk("error", {127'd0, error}, {127'd0, r.error});
                  chk("busy_at_done", {127'd0, busy}, 128'd0);
                  if (r.found) chk("nonce", {96'd0, nonce}, {96'd0, r.nonce});
                  if (r.lat >= 0) chk("timeout_latency", 128'(cyc - valid_cyc), 128'(r.lat));
                  chk("init_count", 128'(exp_blk.size()), 128'd0);
               end
            end
         end
         prev_init = hash_init;
         prev_done = done;
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_hash_init"}, {127'd0, hash_init}, 128'd0);
      chk({tag, "_valid"},     {127'd0, valid},     128'd0);
      chk({tag, "_block_out"}, block_out,           128'd0);
      chk({tag, "_nonce"},     {96'd0, nonce},      128'd0);
      chk({tag, "_found"},     {127'd0, found},     128'd0);
      chk({tag, "_done"},      {127'd0, done},      128'd0);
      chk({tag, "_error"},     {127'd0, error},     128'd0);
      chk({tag, "_busy"},      {127'd0, busy},      128'd0);
   endtask

   // One search: queue expectations, pulse start, optionally poke start
   // while busy, and wait (bounded) for done.
   task automatic run(input logic [95:0] pl, input logic [15:0] tg, input logic [31:0] mx,
                      input logic ef, input logic [31:0] en, input logic ee, input int lat,
                      input int nblk, input int poke);
      res_t r;
      int   n;
      for (int i = 0; i < nblk; i++) exp_blk.push_back({32'(i), pl});
      r.found = ef; r.nonce = en; r.error = ee; r.lat = lat;
      exp_res.push_back(r);
      @(negedge clk);
      payload = pl; target = tg; max_nonce = mx; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 3000) begin
         if (n == poke) begin
            payload = ~pl; target = 16'hFFFF; max_nonce = 32'd0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL done_wait: got done=0 expected done=1 within 3000 cycles");
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; payload = 96'd0; target = 16'd0; max_nonce = 32'd0;
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // First-nonce hit: hash[23:8]=0x0001 < 0x0200.
      model_mode = 1; model_hash = 24'h000100;
      run(96'h0123456789ABCDEF01234567, 16'h0200, 32'd10, 1'b1, 32'd0, 1'b0, -1, 1, -1);

      // Exhaustion over nonces 0..3.
      model_hash = 24'hFFFFFF;
      run(96'hA5A5A5A5_5A5A5A5A_C3C3C3C3, 16'h0200, 32'd3, 1'b0, 32'd0, 1'b0, -1, 4, -1);

      // Hit at nonce 2, with a start pulse while busy that must be ignored.
      model_mode = 2;
      run(96'h111122223333444455556666, 16'h0001, 32'd5, 1'b1, 32'd2, 1'b0, -1, 3, 4);

      // Timeout: engine never answers; done 1024 cycles after the valid strobe.
      model_mode = 0;
      run(96'hDEADBEEF_CAFEF00D_12345678, 16'h0200, 32'd5, 1'b0, 32'd0, 1'b1, 1024, 1, -1);

      // Stale ready: the stale FFFFFF must not be taken; 000100 after the drop hits.
      hash_in = 24'hFFFFFF; hash_ready = 1'b1; model_mode = 3;
      run(96'h0F0F0F0F_F0F0F0F0_00FF00FF, 16'h0200, 32'd0, 1'b1, 32'd0, 1'b0, -1, 1, -1);

      // Reset asserted in WAIT clears outputs without a clock edge.
      model_mode = 0;
      exp_blk.push_back({32'd0, 96'h777788889999AAAABBBBCCCC});
      @(negedge clk);
      payload = 96'h777788889999AAAABBBBCCCC; target = 16'h0200; max_nonce = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1 check_all_zero("async_rst");
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_reset_busy", {127'd0, busy}, 128'd0);
      chk("post_reset_queue", 128'(exp_res.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/micro_ucr_hash_driver.md
MICRO_UCR_HASH_DRIVER -- requirements
Module: micro_ucr_hash_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of cycles spent in WAIT before aborting a round.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin a nonce search.
REQ-005 SHALL have port payload, input, 96, the fixed block bytes.
REQ-006 SHALL have port target, input, 16, the difficulty threshold.
REQ-007 SHALL have port max_nonce, input, 32, the last nonce to try.
REQ-008 SHALL have port hash_init, output reg, 1, the hash-engine start strobe.
REQ-009 SHALL have port valid, output reg, 1, which qualifies block_out.
REQ-010 SHALL have port block_out, output reg, 128, the block to the engine; [127:96] carry the nonce and [95:0] carry the payload.
REQ-011 SHALL have port hash_in, input, 24, the engine result.
REQ-012 SHALL have port hash_ready, input, 1, the engine result-valid signal.
REQ-013 SHALL have port nonce, output reg, 32, the winning nonce.
REQ-014 SHALL have ports found, done, error and busy, each output reg, 1, carrying search status.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, SEND, WAIT, CHECK.
REQ-016 In IDLE, busy=0; on start=1 the block SHALL make the following updates, then go to INIT:
- latch payload, target and max_nonce;
- set the internal nonce counter to 0;
- clear found, done and error;
- set busy=1.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 In INIT the block SHALL assert hash_init=1 for exactly one cycle, drive block_out={counter, payload}, clear the armed flag, and go to SEND.
REQ-019 In SEND the block SHALL assert valid=1 for exactly one cycle with block_out unchanged, then go to WAIT.
REQ-020 block_out SHALL stay stable from INIT through the end of WAIT.
REQ-021 In WAIT, hash_in SHALL be captured only on hash_ready=1 with the armed flag set.
REQ-022 The armed flag SHALL be set by any WAIT cycle in which hash_ready=0, so that a stale hash_ready high carried over from the prior round is never accepted.
REQ-023 On capture the block SHALL go to CHECK; the timeout counter SHALL reset on entry to WAIT.
REQ-024 If the WAIT cycle count reaches TIMEOUT, the block SHALL set error=1, done=1 and busy=0, and go to IDLE.
REQ-025 In CHECK, success is defined as captured hash[23:8] < target, an unsigned 16-bit compare.
REQ-026 On success the block SHALL set nonce=counter, found=1, done=1 and busy=0, and go to IDLE.
REQ-027 Otherwise, if counter == max_nonce, the block SHALL set done=1, found=0 and busy=0, and go to IDLE.
REQ-028 Otherwise the block SHALL increment counter by 1 and go to INIT.
REQ-029 hash_init SHALL be 0 during CHECK and IDLE, guaranteeing at least one deasserted cycle between successive hash_init pulses.
REQ-030 The counter SHALL never wrap; max_nonce=32'hFFFFFFFF terminates at FFFFFFFF without overflow.
REQ-031 found, done, error and nonce SHALL hold their values until the next accepted start.
REQ-032 valid and hash_init SHALL never be asserted in the same cycle.

Reset
REQ-033 On reset=0, regardless of clk, the block SHALL:
- force the FSM to IDLE;
- clear the counter, the timeout counter and the armed flag;
- clear the latched payload, target and max_nonce;
- drive hash_init=0, valid=0, block_out=0, nonce=0, found=0, done=0, error=0 and busy=0.
REQ-034 Reset asserted mid-search SHALL abort the search with no further hash_init or valid pulses until a new start after reset release.

Verification
REQ-035 Bench SHALL cover first-nonce hit: target=16'h0200, model returns hash 24'h000100 -> exactly one hash_init, found=1, nonce=0, done=1, error=0.
REQ-036 Bench SHALL cover exhaustion: max_nonce=3, model always returns 24'hFFFFFF -> 4 hash_init pulses with block_out[127:96]=0,1,2,3, then done=1, found=0.
REQ-037 Bench SHALL cover a hit at nonce 2:
- stimulus: model returns 24'h000000 only when block nonce=2, target=16'h0001;
- response: found=1, nonce=2.
REQ-038 Bench SHALL cover timeout: model never asserts hash_ready, TIMEOUT=1023 -> error=1, done=1, busy=0 after 1023 WAIT cycles.
REQ-039 Bench SHALL cover stale ready: hash_ready held 1 through INIT/SEND and dropped for 1 cycle, then the model returns 24'h000100 -> the result is captured only after the drop.
REQ-040 Bench SHALL cover reset and busy start:
- reset=0 in WAIT: all outputs read 0 immediately with no clk edge required;
- start pulsed while busy=1: no effect on counter or latched inputs.
